// File: rtl/drap_ifetch_pc.sv
`default_nettype none
// ============================================================================
// Module   : drap_ifetch_pc
// Purpose  : Program counter and IF/ID pipeline register for the MIPS fetch
//            stage. Picks the next PC (jump > branch > stall-hold > PC+4),
//            latches the fetched instruction and PC+4, and inserts bubbles on
//            redirects and flushes.
// Ports    : clk, rst_n           - clock, asynchronous active-low reset
//            pc_out               - current PC (register output)
//            pc_plus4_in          - external adder sum of pc_out + 4
//            imem_rdata           - instruction word at pc_out
//            branch_taken/_target - branch redirect request and destination
//            jump/jump_target     - jump redirect request and destination
//            stall, flush         - hazard-unit controls
//            if_id_instr/_pc4/_valid - IF/ID register contents
//            addr_err             - sticky misaligned-redirect flag
// Revision : 1.0 - initial release
// ============================================================================
module drap_ifetch_pc #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] pc_out,
  input  logic [31:0] pc_plus4_in,
  input  logic [31:0] imem_rdata,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        stall,
  input  logic        flush,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid,
  output logic        addr_err
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;
  logic        err_q, err_d;

  logic        redirect;
  logic [31:0] target;

  // Jump wins over branch, so the misalignment check only looks at the
  // target that is actually taken.
  assign redirect = jump | branch_taken;
  assign target   = jump ? jump_target : branch_target;

  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    err_d   = err_q;

    if (redirect) begin
      // Redirects override stall; the low bits are dropped so fetch stays
      // word aligned even when the target is bad.
      pc_d    = {target[31:2], 2'b00};
      instr_d = NOP_INSTR;
      pc4_d   = 32'h0000_0000;
      valid_d = 1'b0;
      if (target[1:0] != 2'b00) begin
        err_d = 1'b1;
      end
    end else begin
      if (!stall) begin
        pc_d = pc_plus4_in;
      end
      if (flush) begin
        instr_d = NOP_INSTR;
        pc4_d   = 32'h0000_0000;
        valid_d = 1'b0;
      end else if (!stall) begin
        instr_d = imem_rdata;
        pc4_d   = pc_plus4_in;
        valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
      pc4_q   <= 32'h0000_0000;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign pc_out      = pc_q;
  assign if_id_instr = instr_q;
  assign if_id_pc4   = pc4_q;
  assign if_id_valid = valid_q;
  assign addr_err    = err_q;

endmodule
`default_nettype wire

// File: tb/tb_drap_ifetch_pc.sv
`default_nettype none
// ============================================================================
// Module   : tb_drap_ifetch_pc
// Purpose  : Self-checking bench for drap_ifetch_pc. The bench plays the PC+4
//            adder and instruction memory (instr = addr ^ 32'hA5A5_0000) and
//            tracks expected state with a rule-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_drap_ifetch_pc;

  localparam logic [31:0] C_MEM_XOR = 32'hA5A5_0000;

  logic        clk;
  logic        rst_n;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4_in;
  logic [31:0] imem_rdata;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic        stall;
  logic        flush;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc4;
  logic        if_id_valid;
  logic        addr_err;

  int n_cmp;
  int n_err;

  // reference model state
  logic [31:0] m_pc, m_instr, m_pc4;
  logic        m_valid, m_err;

  drap_ifetch_pc dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pc_out       (pc_out),
    .pc_plus4_in  (pc_plus4_in),
    .imem_rdata   (imem_rdata),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .jump         (jump),
    .jump_target  (jump_target),
    .stall        (stall),
    .flush        (flush),
    .if_id_instr  (if_id_instr),
    .if_id_pc4    (if_id_pc4),
    .if_id_valid  (if_id_valid),
    .addr_err     (addr_err)
  );

  // external adder and instruction memory
  assign pc_plus4_in = pc_out + 32'd4;
  assign imem_rdata  = pc_out ^ C_MEM_XOR;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pc    = 32'h0;
    m_instr = 32'h0;
    m_pc4   = 32'h0;
    m_valid = 1'b0;
    m_err   = 1'b0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".pc"},    pc_out,      m_pc);
    chk({tag, ".instr"}, if_id_instr, m_instr);
    chk({tag, ".pc4"},   if_id_pc4,   m_pc4);
    chk({tag, ".valid"}, {31'd0, if_id_valid}, {31'd0, m_valid});
    chk({tag, ".err"},   {31'd0, addr_err},    {31'd0, m_err});
  endtask

  // Advance the model by one edge from the current inputs, clock the DUT,
  // then compare just after the edge.
  task automatic cycle(input string tag);
    logic [31:0] tgt;
    logic [31:0] seq_pc4;
    logic [31:0] seq_instr;
    seq_pc4   = m_pc + 32'd4;
    seq_instr = m_pc ^ C_MEM_XOR;
    if (jump || branch_taken) begin
      tgt = jump ? jump_target : branch_target;
      if ((tgt % 4) != 0) m_err = 1'b1;
      m_pc    = tgt - (tgt % 4);
      m_instr = 32'h0;
      m_pc4   = 32'h0;
      m_valid = 1'b0;
    end else begin
      if (flush) begin
        m_instr = 32'h0;
        m_pc4   = 32'h0;
        m_valid = 1'b0;
      end else if (!stall) begin
        m_instr = seq_instr;
        m_pc4   = seq_pc4;
        m_valid = 1'b1;
      end
      if (!stall) m_pc = seq_pc4;
    end
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic idle_inputs();
    branch_taken  = 1'b0;
    branch_target = 32'h0;
    jump          = 1'b0;
    jump_target   = 32'h0;
    stall         = 1'b0;
    flush         = 1'b0;
  endtask

  // Pulse reset between edges and check the immediate effect.
  task automatic mid_reset(input string tag);
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all(tag);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    idle_inputs();
    rst_n = 1'b0;
    model_reset();
    #12;
    check_all("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    // that edge happened with rst_n high: first normal fetch from 0
    m_pc = 32'h4; m_instr = 32'hA5A5_0000; m_pc4 = 32'h4; m_valid = 1'b1;
    check_all("fetch1");
    cycle("fetch2");
    chk("fetch2.instr_abs", if_id_instr, 32'hA5A5_0004);
    chk("fetch2.pc_abs", pc_out, 32'h8);

    // branch at pc 8 to 0x40
    branch_taken = 1'b1; branch_target = 32'h40;
    cycle("branch");
    chk("branch.pc_abs", pc_out, 32'h40);
    idle_inputs();
    cycle("branch_next");
    chk("branch_next.instr_abs", if_id_instr, 32'hA5A5_0040);
    chk("branch_next.pc4_abs", if_id_pc4, 32'h44);

    // jump + branch + stall together
    jump = 1'b1; jump_target = 32'h100;
    branch_taken = 1'b1; branch_target = 32'h80;
    stall = 1'b1;
    cycle("jmp_br_stall");
    chk("jmp_br_stall.pc_abs", pc_out, 32'h100);
    idle_inputs();
    cycle("after_jump");

    // stall for 3 cycles
    stall = 1'b1;
    for (int i = 0; i < 3; i++) cycle("stall3");
    idle_inputs();
    cycle("after_stall");

    // flush alone, then flush with stall
    flush = 1'b1;
    cycle("flush");
    stall = 1'b1;
    cycle("flush_stall");
    idle_inputs();
    cycle("after_flush");

    // misaligned branch
    branch_taken = 1'b1; branch_target = 32'h0000_0203;
    cycle("misalign");
    chk("misalign.pc_abs", pc_out, 32'h200);
    chk("misalign.err_abs", {31'd0, addr_err}, 32'd1);
    idle_inputs();
    for (int i = 0; i < 4; i++) cycle("err_sticky");

    // async reset mid-stream
    mid_reset("async_rst");
    chk("async_rst.pc_abs", pc_out, 32'h0);
    cycle("post_rst");

    // wrap-around near the top of the address space
    jump = 1'b1; jump_target = 32'hFFFF_FFF8;
    cycle("wrap_jump");
    idle_inputs();
    for (int i = 0; i < 3; i++) cycle("wrap");

    // randomized phase
    for (int i = 0; i < 400; i++) begin
      idle_inputs();
      stall        = ($urandom_range(0, 3) == 0);
      flush        = ($urandom_range(0, 6) == 0);
      branch_taken = ($urandom_range(0, 6) == 0);
      jump         = ($urandom_range(0, 9) == 0);
      branch_target = $urandom & 32'h0000_FFFC;
      jump_target   = $urandom & 32'h000F_FFFC;
      if ($urandom_range(0, 4) == 0) branch_target[1:0] = 2'($urandom_range(1, 3));
      if ($urandom_range(0, 4) == 0) jump_target[1:0]   = 2'($urandom_range(1, 3));
      cycle("rand");
      if ($urandom_range(0, 59) == 0) begin
        idle_inputs();
        mid_reset("rand_rst");
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
